// File: rtl/burst_mem_responder.sv
// Burst-command target over a word-addressed block-RAM store; each word is paced by a one-cycle ready strobe.
// Optional BURST_RESP_INIT_CLEAR_EN: zero-fills the store after reset and holds the first command seen meanwhile.
module burst_mem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int LATENCY    = 3,
    parameter int GAP        = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        burst_en,
    input  logic [7:0]  burst_length,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        we,
    input  logic        rd,
    output logic [31:0] spo,
    output logic        ready,
    output logic        busy
);
    typedef logic [ADDR_WIDTH-1:0] idx_t;
    localparam idx_t       IDX_ONE  = idx_t'(1);
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);
    localparam logic [3:0] GAP_LOAD = 4'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_XFER
`ifdef BURST_RESP_INIT_CLEAR_EN
        , S_INIT
`endif
    } state_t;

    state_t      r_state, w_nxt_state;
    logic [3:0]  r_delay, w_nxt_delay;
    logic [8:0]  r_left, w_nxt_left;
    idx_t        r_idx, w_nxt_idx;
    logic        r_wr, w_nxt_wr;
    logic [31:0] r_spo;
    logic [31:0] r_mem [0:(1<<ADDR_WIDTH)-1];

    logic        w_cmd, w_load, w_ready, w_spo_load, w_unused;
    idx_t        w_cmd_idx;
    logic [8:0]  w_cmd_len;
    logic        w_go, w_go_wr;
    idx_t        w_go_idx;
    logic [8:0]  w_go_len;
    logic        w_mem_we;
    idx_t        w_mem_addr;
    logic [31:0] w_mem_data;

    assign w_cmd     = rd | we;
    assign w_cmd_idx = a[ADDR_WIDTH+1:2];
    assign w_cmd_len = (!burst_en || burst_length == 8'd0) ? 9'd1 : {1'b0, burst_length};
    assign w_unused  = ^{a[31:ADDR_WIDTH+2], a[1:0]};

`ifdef BURST_RESP_INIT_CLEAR_EN
    logic       r_pend, r_pend_wr;
    idx_t       r_pend_idx, r_clr;
    logic [8:0] r_pend_len;

    // A command held during the clear takes priority over whatever is on the pins when INIT exits.
    assign w_go     = r_pend | w_cmd;
    assign w_go_idx = r_pend ? r_pend_idx : w_cmd_idx;
    assign w_go_len = r_pend ? r_pend_len : w_cmd_len;
    assign w_go_wr  = r_pend ? r_pend_wr  : we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr      <= '0;
            r_pend     <= 1'b0;
            r_pend_idx <= '0;
            r_pend_len <= '0;
            r_pend_wr  <= 1'b0;
        end else if (r_state == S_INIT) begin
            r_clr <= r_clr + IDX_ONE;
            if (!r_pend && w_cmd) begin
                r_pend     <= 1'b1;
                r_pend_idx <= w_cmd_idx;
                r_pend_len <= w_cmd_len;
                r_pend_wr  <= we;
            end
        end else begin
            r_pend <= 1'b0;
        end
    end
`else
    assign w_go     = w_cmd;
    assign w_go_idx = w_cmd_idx;
    assign w_go_len = w_cmd_len;
    assign w_go_wr  = we;
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_delay = r_delay;
        w_nxt_left  = r_left;
        w_nxt_idx   = r_idx;
        w_nxt_wr    = r_wr;
        w_ready     = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: w_load = w_go;
            S_WAIT, S_XFER: begin
                if (r_delay != 4'd0) begin
                    w_nxt_delay = r_delay - 4'd1;
                end else begin
                    w_ready = 1'b1;
                    if (r_left <= 9'd1) begin
                        w_nxt_state = S_IDLE;
                    end else begin
                        w_nxt_state = S_XFER;
                        w_nxt_delay = GAP_LOAD;
                        w_nxt_left  = r_left - 9'd1;
                        w_nxt_idx   = r_idx + IDX_ONE;
                    end
                end
            end
`ifdef BURST_RESP_INIT_CLEAR_EN
            S_INIT: begin
                if (r_clr == '1) begin
                    w_nxt_state = S_IDLE;
                    w_load      = w_go;
                end
            end
`endif
            default: w_nxt_state = S_IDLE;
        endcase
        if (w_load) begin
            w_nxt_state = S_WAIT;
            w_nxt_delay = LAT_LOAD;
            w_nxt_left  = w_go_len;
            w_nxt_idx   = w_go_idx;
            w_nxt_wr    = w_go_wr;
        end
    end

    // Read data is fetched on the edge before the ready cycle so spo is already valid while ready is high.
    assign w_spo_load = (w_nxt_state == S_WAIT || w_nxt_state == S_XFER) &&
                        (w_nxt_delay == 4'd0) && !w_nxt_wr;

    always_comb begin
        w_mem_we   = w_ready & r_wr & ~rst;
        w_mem_addr = r_idx;
        w_mem_data = d;
`ifdef BURST_RESP_INIT_CLEAR_EN
        if (r_state == S_INIT) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_clr;
            w_mem_data = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (w_mem_we)
            r_mem[w_mem_addr] <= w_mem_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef BURST_RESP_INIT_CLEAR_EN
            r_state <= S_INIT;
`else
            r_state <= S_IDLE;
`endif
            r_delay <= '0;
            r_left  <= '0;
            r_idx   <= '0;
            r_wr    <= 1'b0;
            r_spo   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_delay <= w_nxt_delay;
            r_left  <= w_nxt_left;
            r_idx   <= w_nxt_idx;
            r_wr    <= w_nxt_wr;
            if (w_spo_load)
                r_spo <= (w_mem_we && w_mem_addr == w_nxt_idx) ? w_mem_data : r_mem[w_nxt_idx];
        end
    end

    assign spo   = r_spo;
    assign ready = w_ready;
    assign busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_burst_mem_responder.sv
// Scoreboard bench for burst_mem_responder: commands push expected ready cycles/data; a negedge monitor checks them.
module tb_burst_mem_responder;
    localparam int AW    = 5;
    localparam int DEPTH = 1 << AW;
    localparam int LAT   = 3;
    localparam int GP    = 2;

    logic        clk = 1'b0;
    logic        rst, burst_en, we, rd, ready, busy;
    logic [7:0]  burst_length;
    logic [31:0] a, d, spo;

    always #5 clk = ~clk;

    burst_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT), .GAP(GP)) dut (
        .clk(clk), .rst(rst), .burst_en(burst_en), .burst_length(burst_length),
        .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready), .busy(busy)
    );

    typedef struct {
        int unsigned cyc;
        bit          is_rd;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mdl [DEPTH];
    logic [31:0] wbuf [256];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missed_ready: expected ready at cycle %0d, still absent at cycle %0d", e.cyc, cyc);
        end
        if (ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL spurious_ready: ready=1 at cycle %0d, required 0", cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc) begin
                    n_errors++;
                    $display("FAIL ready_timing: ready at cycle %0d, required cycle %0d", cyc, e.cyc);
                end else if (e.is_rd && spo !== e.data) begin
                    n_errors++;
                    $display("FAIL read_data: spo=%h at cycle %0d, required %h", spo, cyc, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic wait_idle();
        int unsigned budget;
        budget = DEPTH + 50;
        while (busy && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Issue one command at a negedge; t_exec overrides the cycle the command is considered sampled in.
    task automatic do_cmd(input logic r, input logic w, input logic [31:0] addr, input logic ben,
                          input logic [7:0] blen, input int unsigned stop_after, input int unsigned t_exec);
        int unsigned n, nw, idx, t0, i, budget;
        logic [31:0] last_rd, spo_before;
        n  = (ben && blen != 8'd0) ? 32'(blen) : 32'd1;
        nw = (stop_after < n) ? stop_after : n;
        idx = 32'(addr[AW+1:2]);
        t0 = (t_exec != 0) ? t_exec : cyc;
        spo_before = spo;
        last_rd = spo;
        for (int k = 0; k < int'(nw); k++) begin
            exp_t e;
            logic [AW-1:0] wi;
            wi = AW'(idx + 32'(k));
            e.cyc   = t0 + LAT + 32'(k) * GP;
            e.is_rd = !w;
            e.data  = mdl[wi];
            if (w) mdl[wi] = wbuf[8'(k)];
            else last_rd = e.data;
            exp_q.push_back(e);
        end
        rd = r; we = w; a = addr; burst_en = ben; burst_length = blen; d = wbuf[0];
        i = 0;
        budget = LAT + GP * n + DEPTH + 20;
        while (i < nw && budget > 0) begin
            @(negedge clk);
            budget--;
            rd = 1'b0;
            we = 1'b0;
            if (ready) begin
                i++;
                if (w && i < nw) begin
                    @(posedge clk);
                    #1;
                    d = wbuf[8'(i)];
                end
            end else if (busy && $urandom_range(0, 3) == 0) begin
                rd = 1'($urandom);
                we = 1'($urandom);
                a = $urandom;
                burst_en = 1'($urandom);
                burst_length = 8'($urandom);
            end
        end
        rd = 1'b0;
        we = 1'b0;
        if (i < nw) chk("ready_timeout", i, nw);
        if (stop_after >= n) begin
            @(negedge clk);
            chk("busy_after_burst", 32'(busy), 32'd0);
            if (w) chk("spo_unchanged_by_write", spo, spo_before);
            else   chk("spo_hold", spo, last_rd);
        end
    endtask

    initial begin
        int unsigned p;
        logic [31:0] ra;
        rst = 1'b1; rd = 1'b0; we = 1'b0; a = '0; d = '0; burst_en = 1'b0; burst_length = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        p = cyc;
        chk("reset_spo", spo, 32'd0);
        chk("reset_ready", 32'(ready), 32'd0);
`ifdef BURST_RESP_INIT_CLEAR_EN
        chk("reset_busy", 32'(busy), 32'd1);
        for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
        @(negedge clk);
        do_cmd(1'b1, 1'b0, 32'h10, 1'b1, 8'd3, 256, p + DEPTH - 1);
`else
        chk("reset_busy", 32'(busy), 32'd0);
`endif
        for (int k = 0; k < 256; k++) wbuf[k] = $urandom;
        do_cmd(1'b0, 1'b1, 32'h0, 1'b1, 8'(DEPTH), 256, 0);

        for (int k = 0; k < 4; k++) wbuf[k] = 32'hA0 + 32'(k);
        do_cmd(1'b0, 1'b1, 32'h100, 1'b1, 8'd4, 256, 0);
        do_cmd(1'b1, 1'b0, 32'h100, 1'b1, 8'd4, 256, 0);

        for (int k = 0; k < 4; k++) wbuf[k] = 32'(k + 1);
        do_cmd(1'b0, 1'b1, 32'((DEPTH - 2) * 4), 1'b1, 8'd4, 256, 0);
        do_cmd(1'b1, 1'b0, 32'hABCD_EF7B, 1'b1, 8'd4, 256, 0);

        do_cmd(1'b1, 1'b0, 32'h8, 1'b0, 8'd32, 256, 0);
        do_cmd(1'b1, 1'b0, 32'h8, 1'b1, 8'd0, 256, 0);

        for (int k = 0; k < 2; k++) wbuf[k] = $urandom;
        do_cmd(1'b1, 1'b1, 32'h20, 1'b1, 8'd2, 256, 0);
        do_cmd(1'b1, 1'b0, 32'h20, 1'b1, 8'd2, 256, 0);

        for (int k = 0; k < 256; k++) wbuf[k] = $urandom;
        do_cmd(1'b0, 1'b1, $urandom, 1'b1, 8'd255, 256, 0);
        do_cmd(1'b1, 1'b0, 32'h0, 1'b1, 8'(DEPTH), 256, 0);

        for (int t = 0; t < 40; t++) begin
            int unsigned kind;
            logic [7:0]  bl;
            kind = $urandom_range(0, 2);
            bl = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            for (int k = 0; k < 256; k++) wbuf[k] = $urandom;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_cmd(kind != 1, kind != 0, $urandom, 1'($urandom), bl, 256, 0);
        end

        // Reset in the gap after the second of eight writes.
        for (int k = 0; k < 256; k++) wbuf[k] = $urandom;
        ra = $urandom;
        do_cmd(1'b0, 1'b1, ra, 1'b1, 8'd8, 2, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_spo", spo, 32'd0);
`ifdef BURST_RESP_INIT_CLEAR_EN
        chk("abort_busy", 32'(busy), 32'd1);
        for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
        wait_idle();
`else
        chk("abort_busy", 32'(busy), 32'd0);
`endif
        do_cmd(1'b1, 1'b0, ra, 1'b1, 8'd8, 256, 0);

        for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/burst_mem_responder.md
Name: burst_mem_responder

Overview:
- Target side of the lowmem burst interface that the CPU cache drives. It accepts single-cycle rd/we burst commands with a block-aligned base address and a burst length.
- It then serves or consumes data one word at a time from an internal block-RAM backing store, paced by ready pulses.
- Used as the cache's lowmem in simulation and small FPGA builds, and as the reference model when verifying the cache's LOAD/WRITEBACK paths.

Parameters:
- ADDR_WIDTH, 12, word-address width; backing store depth = 2^ADDR_WIDTH words of 32 bits.
- LATENCY, 3, cycles from command sample to first ready pulse; legal range 1..15.
- GAP, 2, cycles between consecutive ready pulses within a burst; legal range 1..15.

Ports:
- clk  input  1  clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- burst_en  input  1  1 = burst of burst_length words; 0 = single word.
- burst_length  input  8  words in burst; 0 is treated as 1.
- a  input  32  byte address; word index = a[ADDR_WIDTH+1:2].
- d  input  32  write data, sampled on ready cycles of a write burst.
- we  input  1  write-burst command strobe.
- rd  input  1  read-burst command strobe.
- spo  output  32  read data, registered.
- ready  output  1  one-cycle per-word strobe.
- busy  output  1  high from command acceptance until IDLE is re-entered.

Behaviour:
- Reset: spo=0, ready=0, busy=0, state=IDLE, word and delay counters=0. Backing-store contents are not reset.
- States:
  - IDLE: command accepted when (rd|we) is high. Latch idx, len (burst_en ? max(burst_length,1) : 1), dir, delay=LATENCY-1. -> WAIT, busy=1.
  - WAIT: delay decrements to 0; then ready=1 for word 0 (the first ready is LATENCY cycles after the command cycle). -> XFER.
  - XFER: ready asserts GAP cycles after the previous ready. The cycle after the ready for word len-1: -> IDLE, busy=0.
  - A new command is accepted in that IDLE cycle, i.e. one cycle after the last ready.
- Read path: during the ready cycle for word i, spo = mem[(idx+i) mod 2^ADDR_WIDTH]. spo holds that value until the next word's ready cycle, or indefinitely after the burst ends.
- Write path: on the ready cycle for word i, mem[(idx+i) mod depth] <= d. The initiator must present word i+1 on d before the next ready, which is at least GAP cycles later.
- Simultaneous rd & we in IDLE: write wins; the read is dropped.
- Commands while busy: ignored, with no side effects.
- Address wrap: the index increments modulo depth. Bits of a above ADDR_WIDTH+1 and a[1:0] are ignored.
- Word counter: 9 bits, so len=256 completes. A burst of length n produces exactly n ready pulses.
- rst mid-burst: aborts the burst immediately with ready=0 next cycle. Writes already performed are kept; no further words are written.
- ready is never high in IDLE or during WAIT delay cycles.

Optional Feature:
- Macro BURST_RESP_INIT_CLEAR_EN.
- Defined:
  - After rst, an INIT state writes 0 to every word, one per cycle, over 2^ADDR_WIDTH cycles, with busy=1 and ready=0.
  - One command (rd or we, with a, burst_en, burst_length) arriving during INIT is latched, first one wins, and executed as if sampled in the cycle INIT exits.
  - Further commands during INIT are ignored.
  - rst during INIT restarts the clear.
- Undefined: no INIT state. IDLE follows reset directly, memory holds its initial/previous contents, and commands are accepted in the first cycle after rst deasserts.

Test Plan:
- LATENCY=3, GAP=2. Write burst a=0x100, burst_en=1, len=4, d=0xA0..0xA3 advanced after each ready -> ready at T+3, T+5, T+7, T+9; busy falls at T+10; words 0x40..0x43 hold 0xA0..0xA3.
- Read burst a=0x100, len=4 after the previous write -> spo=0xA0,0xA1,0xA2,0xA3 on the four ready cycles; exactly 4 ready pulses.
- ADDR_WIDTH=4, write a=0x38 (idx 14), len=4, d=1,2,3,4 -> mem[14]=1, mem[15]=2, mem[0]=3, mem[1]=4.
- burst_en=0 with burst_length=32, rd, a=0x8 -> a single ready; spo=mem[2]. Then burst_en=1, len=0 -> a single ready.
- Second rd asserted while busy, then rd & we together in IDLE with len=2 -> the busy command produces no ready; the combined command writes 2 words and returns no read data.
- rst asserted after the second ready of a len=8 write -> ready=0 and busy=0 next cycle; only 2 words are modified. With BURST_RESP_INIT_CLEAR_EN and ADDR_WIDTH=4: rd issued in cycle 2 of INIT -> first ready LATENCY cycles after INIT exits; data = 0.
